// File: rtl/riscv_fetch_pkg.sv
// Shared types for the fetch PC generator: FSM state, shadow-stage record and default boot PC.
package riscv_fetch_pkg;

    typedef enum logic [0:0] {
        StBoot  = 1'b0,
        StFetch = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic        valid;
    } shadow_stage_t;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
    localparam int unsigned BootCntW       = 4;

endpackage

// File: rtl/pred_shadow_pipe.sv
// Two-entry shadow pipeline carrying each fetched PC and its prediction to the resolve stage.
module pred_shadow_pipe
    import riscv_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          hold_hi,
    input  logic          bubble_lo,
    input  logic          clear,
    input  shadow_stage_t stage_in,
    output shadow_stage_t stage_2,
    output shadow_stage_t stage_3
);

    shadow_stage_t s2_q, s2_d;
    shadow_stage_t s3_q, s3_d;

    always_comb begin
        s2_d = s2_q;
        s3_d = s3_q;
        if (clear) begin
            s2_d.valid = 1'b0;
            s2_d.pred  = 1'b0;
            s3_d.valid = 1'b0;
            s3_d.pred  = 1'b0;
        end else begin
            if (advance && !hold_hi) begin
                s2_d = stage_in;
            end
            // A bubble keeps the stale PC visible but drops validity and prediction.
            if (bubble_lo) begin
                s3_d.valid = 1'b0;
                s3_d.pred  = 1'b0;
            end else if (advance) begin
                s3_d = s2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign stage_2 = s2_q;
    assign stage_3 = s3_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register, boot FSM and flush/stall priority downstream of the BTB.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_gen
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DefaultResetPc,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memory_stall,
    input  logic        hazard_stall,
    input  logic [31:0] btb_branch_pc,
    input  logic        btb_flush,
    input  logic        btb_taken,
    output logic [31:0] pc_1,
    output logic        icache_req,
    output logic [31:0] pc_2,
    output logic        valid_2,
    output logic [31:0] pc_3,
    output logic        pred_taken_3,
    output logic        valid_3,
    output logic        squash
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam logic [BootCntW-1:0] BootInit     = BootCntW'(BOOT_CYCLES - 1);
    localparam logic [31:0]         ResetPcAlign = {RESET_PC[31:2], 2'b00};

    fetch_state_e        state_q;
    logic [BootCntW-1:0] boot_cnt_q;
    logic [31:0]         pc_1_q;

    logic run;
    logic flush_apply;
    logic hazard_apply;
    logic advance;

    shadow_stage_t stage_in;
    shadow_stage_t stage_2;
    shadow_stage_t stage_3;

    // Flush outranks the load-use stall; a memory stall defers both.
    assign run          = (state_q == StFetch) && !memory_stall;
    assign flush_apply  = run && btb_flush;
    assign hazard_apply = run && !btb_flush && hazard_stall;
    assign advance      = run && !btb_flush && !hazard_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            boot_cnt_q <= BootInit;
            pc_1_q     <= ResetPcAlign;
        end else begin
            case (state_q)
                StBoot: begin
                    if (boot_cnt_q == '0) begin
                        state_q <= StFetch;
                    end else begin
                        boot_cnt_q <= boot_cnt_q - 1'b1;
                    end
                end
                StFetch: begin
                    if (flush_apply || advance) begin
                        pc_1_q <= {btb_branch_pc[31:2], 2'b00};
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign stage_in = '{pc: pc_1_q, pred: btb_taken, valid: 1'b1};

    pred_shadow_pipe u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
        .hold_hi   (hazard_apply),
        .bubble_lo (hazard_apply),
        .clear     (flush_apply),
        .stage_in  (stage_in),
        .stage_2   (stage_2),
        .stage_3   (stage_3)
    );

    assign pc_1         = pc_1_q;
    assign icache_req   = (state_q == StFetch);
    assign pc_2         = stage_2.pc;
    assign valid_2      = stage_2.valid;
    assign pc_3         = stage_3.pc;
    assign pred_taken_3 = stage_3.pred;
    assign valid_3      = stage_3.valid;
    assign squash       = flush_apply;

    logic unused_sigs;
    assign unused_sigs = ^{btb_branch_pc[1:0], stage_2.pred};

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (advance && (perf_fetch_q != '1)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (flush_apply && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: stage-3 results are predicted at fetch time and checked on arrival.
module tb_fetch_pc_gen;

    localparam logic [31:0] RstPc = 32'h0000_0100;
    localparam int unsigned Boot  = 2;

    localparam int EdgeNone  = 0;
    localparam int EdgeAdv   = 1;
    localparam int EdgeHaz   = 2;
    localparam int EdgeFlush = 3;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } sb_entry_t;

    logic        clk;
    logic        rst_n;
    logic        memory_stall;
    logic        hazard_stall;
    logic [31:0] btb_branch_pc;
    logic        btb_flush;
    logic        btb_taken;
    logic [31:0] pc_1;
    logic        icache_req;
    logic [31:0] pc_2;
    logic        valid_2;
    logic [31:0] pc_3;
    logic        pred_taken_3;
    logic        valid_3;
    logic        squash;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    sb_entry_t   sb[$];
    sb_entry_t   mon_e;
    int          mon_edge = EdgeNone;
    bit          model_fetch;
    int          model_boot;
    logic [31:0] model_pc;

    fetch_pc_gen #(
        .RESET_PC    (RstPc),
        .BOOT_CYCLES (Boot)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memory_stall  (memory_stall),
        .hazard_stall  (hazard_stall),
        .btb_branch_pc (btb_branch_pc),
        .btb_flush     (btb_flush),
        .btb_taken     (btb_taken),
        .pc_1          (pc_1),
        .icache_req    (icache_req),
        .pc_2          (pc_2),
        .valid_2       (valid_2),
        .pc_3          (pc_3),
        .pred_taken_3  (pred_taken_3),
        .valid_3       (valid_3),
        .squash        (squash)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the model is updated from the inputs seen at that edge.
    task automatic tick();
        logic        r  = rst_n;
        logic        ms = memory_stall;
        logic        fl = btb_flush;
        logic        hz = hazard_stall;
        logic        tk = btb_taken;
        logic [31:0] br = btb_branch_pc;
        @(posedge clk);
        if (!r) begin
            model_fetch = 1'b0;
            model_boot  = Boot - 1;
            model_pc    = RstPc;
            sb.delete();
            mon_edge = EdgeNone;
        end else if (!model_fetch) begin
            if (model_boot == 0) model_fetch = 1'b1;
            else model_boot--;
            mon_edge = EdgeNone;
        end else if (ms) begin
            mon_edge = EdgeNone;
        end else if (fl) begin
            model_pc = {br[31:2], 2'b00};
            sb.delete();
            mon_edge = EdgeFlush;
        end else if (hz) begin
            mon_edge = EdgeHaz;
        end else begin
            sb.push_back('{pc: model_pc, pred: tk});
            model_pc = {br[31:2], 2'b00};
            mon_edge = EdgeAdv;
        end
        #1;
    endtask

    // Stage-3 arrival monitor: pops the scoreboard whenever stage 3 is loaded.
    always @(negedge clk) begin
        if (mon_edge == EdgeAdv) begin
            checks++;
            if (sb.size() >= 2) begin
                mon_e = sb.pop_front();
                if (valid_3 !== 1'b1 || pc_3 !== mon_e.pc || pred_taken_3 !== mon_e.pred) begin
                    errors++;
                    $display("FAIL sb_stage3 got v=%0b pc=%h p=%0b want v=1 pc=%h p=%0b",
                             valid_3, pc_3, pred_taken_3, mon_e.pc, mon_e.pred);
                end
            end else if (valid_3 !== 1'b0) begin
                errors++;
                $display("FAIL sb_empty_stage3 got v=%0b want v=0", valid_3);
            end
        end else if (mon_edge == EdgeHaz) begin
            checks++;
            if (valid_3 !== 1'b0 || pred_taken_3 !== 1'b0) begin
                errors++;
                $display("FAIL sb_bubble got v=%0b p=%0b want v=0 p=0", valid_3, pred_taken_3);
            end
        end else if (mon_edge == EdgeFlush) begin
            checks++;
            if (valid_3 !== 1'b0) begin
                errors++;
                $display("FAIL sb_flush got v=%0b want v=0", valid_3);
            end
        end
        mon_edge = EdgeNone;
    end

    task automatic test_reset();
        rst_n = 1'b0; memory_stall = 1'b0; hazard_stall = 1'b0;
        btb_branch_pc = 32'h0; btb_flush = 1'b1; btb_taken = 1'b1;
        tick(); tick();
        checks++;
        if (pc_1 !== RstPc) begin errors++; $display("FAIL rst_pc1 got %h want %h", pc_1, RstPc); end
        checks++;
        if (pc_2 !== 32'h0 || pc_3 !== 32'h0) begin
            errors++; $display("FAIL rst_pcs got %h %h want 0 0", pc_2, pc_3);
        end
        checks++;
        if ({icache_req, valid_2, valid_3, pred_taken_3, squash} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flags got %b want 00000",
                     {icache_req, valid_2, valid_3, pred_taken_3, squash});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (icache_req !== 1'b0 || squash !== 1'b0) begin
            errors++; $display("FAIL boot0 got req=%0b sq=%0b want 0 0", icache_req, squash);
        end
        tick();
        checks++;
        if (icache_req !== 1'b0 || squash !== 1'b0 || pc_1 !== RstPc) begin
            errors++;
            $display("FAIL boot1 got req=%0b sq=%0b pc=%h want 0 0 %h", icache_req, squash, pc_1, RstPc);
        end
        btb_flush = 1'b0; btb_taken = 1'b0;
        tick();
        checks++;
        if (icache_req !== 1'b1 || pc_1 !== RstPc) begin
            errors++; $display("FAIL boot_done got req=%0b pc=%h want 1 %h", icache_req, pc_1, RstPc);
        end
    endtask

    task automatic test_seq();
        btb_taken = 1'b0;
        btb_branch_pc = 32'h104;
        tick();
        checks++;
        if (pc_1 !== 32'h104 || pc_2 !== 32'h100 || valid_2 !== 1'b1) begin
            errors++; $display("FAIL seq1 got pc1=%h pc2=%h v2=%0b want 104 100 1", pc_1, pc_2, valid_2);
        end
        btb_branch_pc = 32'h108;
        tick();
        checks++;
        if (pc_1 !== 32'h108 || pc_3 !== 32'h100 || valid_3 !== 1'b1) begin
            errors++; $display("FAIL seq2 got pc1=%h pc3=%h v3=%0b want 108 100 1", pc_1, pc_3, valid_3);
        end
    endtask

    task automatic test_taken();
        btb_taken = 1'b1; btb_branch_pc = 32'h200;
        tick();
        checks++;
        if (pc_1 !== 32'h200 || pc_2 !== 32'h108) begin
            errors++; $display("FAIL taken_redirect got pc1=%h pc2=%h want 200 108", pc_1, pc_2);
        end
        btb_taken = 1'b0; btb_branch_pc = 32'h204;
        tick();
        checks++;
        if (pc_3 !== 32'h108 || pred_taken_3 !== 1'b1) begin
            errors++; $display("FAIL taken_pred3 got pc3=%h p3=%0b want 108 1", pc_3, pred_taken_3);
        end
    endtask

    task automatic test_hazard();
        hazard_stall = 1'b1; btb_branch_pc = 32'h300;
        tick();
        checks++;
        if (pc_1 !== 32'h204 || pc_2 !== 32'h200 || valid_2 !== 1'b1 || pc_3 !== 32'h108) begin
            errors++;
            $display("FAIL hazard_hold got pc1=%h pc2=%h v2=%0b pc3=%h want 204 200 1 108",
                     pc_1, pc_2, valid_2, pc_3);
        end
        hazard_stall = 1'b0; btb_branch_pc = 32'h208;
        tick();
        checks++;
        if (pc_3 !== 32'h200 || valid_3 !== 1'b1 || pc_1 !== 32'h208) begin
            errors++;
            $display("FAIL hazard_resume got pc3=%h v3=%0b pc1=%h want 200 1 208", pc_3, valid_3, pc_1);
        end
    endtask

    task automatic test_flush_hazard();
        btb_flush = 1'b1; hazard_stall = 1'b1; btb_branch_pc = 32'h340;
        #1;
        checks++;
        if (squash !== 1'b1) begin errors++; $display("FAIL flush_squash got %0b want 1", squash); end
        tick();
        btb_flush = 1'b0; hazard_stall = 1'b0;
        checks++;
        if (pc_1 !== 32'h340 || valid_2 !== 1'b0 || valid_3 !== 1'b0) begin
            errors++;
            $display("FAIL flush_apply got pc1=%h v2=%0b v3=%0b want 340 0 0", pc_1, valid_2, valid_3);
        end
        btb_branch_pc = 32'h344;
        tick();
        checks++;
        if (valid_2 !== 1'b1 || pc_2 !== 32'h340) begin
            errors++; $display("FAIL flush_right_path got v2=%0b pc2=%h want 1 340", valid_2, pc_2);
        end
    endtask

    task automatic test_mem_stall();
        btb_branch_pc = 32'h348;
        tick();
        memory_stall = 1'b1; btb_flush = 1'b1; btb_branch_pc = 32'h500;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (squash !== 1'b0) begin errors++; $display("FAIL stall_squash got %0b want 0", squash); end
            tick();
            checks++;
            if (pc_1 !== 32'h348 || pc_2 !== 32'h344 || valid_2 !== 1'b1 ||
                pc_3 !== 32'h340 || valid_3 !== 1'b1 || icache_req !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold got pc1=%h pc2=%h v2=%0b pc3=%h v3=%0b want 348 344 1 340 1",
                         pc_1, pc_2, valid_2, pc_3, valid_3);
            end
        end
        memory_stall = 1'b0;
        #1;
        checks++;
        if (squash !== 1'b1) begin errors++; $display("FAIL stall_release_squash got %0b want 1", squash); end
        tick();
        btb_flush = 1'b0;
        checks++;
        if (pc_1 !== 32'h500 || valid_2 !== 1'b0 || valid_3 !== 1'b0) begin
            errors++;
            $display("FAIL stall_deferred_flush got pc1=%h v2=%0b v3=%0b want 500 0 0",
                     pc_1, valid_2, valid_3);
        end
    endtask

    task automatic test_wrap();
        btb_branch_pc = 32'hFFFF_FFFC;
        tick();
        checks++;
        if (pc_1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h want fffffffc", pc_1); end
        btb_branch_pc = 32'h0;
        tick();
        checks++;
        if (pc_1 !== 32'h0 || pc_2 !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_zero got pc1=%h pc2=%h want 0 fffffffc", pc_1, pc_2);
        end
        btb_branch_pc = 32'h203;
        tick();
        checks++;
        if (pc_1 !== 32'h200) begin errors++; $display("FAIL align got %h want 200", pc_1); end
        btb_branch_pc = 32'h204;
        tick();
        checks++;
        if (pc_3 !== 32'h0 || valid_3 !== 1'b1) begin
            errors++; $display("FAIL wrap_pc3 got pc3=%h v3=%0b want 0 1", pc_3, valid_3);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (icache_req !== 1'b1 || pc_1 !== RstPc) begin
            errors++; $display("FAIL rerun_boot got req=%0b pc=%h want 1 %h", icache_req, pc_1, RstPc);
        end
        for (int i = 0; i < 5; i++) begin
            btb_branch_pc = model_pc + 32'd4;
            tick();
        end
        btb_flush = 1'b1; btb_branch_pc = 32'h600;
        tick();
        btb_flush = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 32'd5 || perf_flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_counts got %0d %0d want 5 1", perf_fetch_cnt, perf_flush_cnt);
        end
`endif
        checks++;
        if (pc_1 !== 32'h600) begin errors++; $display("FAIL mid_flush got %h want 600", pc_1); end
        rst_n = 1'b0;
        tick();
        checks++;
        if (pc_1 !== RstPc || icache_req !== 1'b0 || valid_2 !== 1'b0 || valid_3 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got pc1=%h req=%0b v2=%0b v3=%0b want %h 0 0 0",
                     pc_1, icache_req, valid_2, valid_3, RstPc);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset got %0d %0d want 0 0", perf_fetch_cnt, perf_flush_cnt);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_seq();
        test_taken();
        test_hazard();
        test_flush_hazard();
        test_mem_stall();
        test_wrap();
        test_reset_mid();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
